// File: rtl/serv_arb_pkg.sv
// Shared types and constants for the serv instruction/data bus memory arbiter.
package serv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic OWNER_IBUS = 1'b0;
  localparam logic OWNER_DBUS = 1'b1;

  // Fetches are always full-word reads.
  localparam logic [3:0] SEL_FULL = 4'hF;
  localparam logic       WE_READ  = 1'b0;

endpackage

// File: rtl/serv_arb_watchdog.sv
// Wait-cycle counter that flags a granted transaction which has waited TIMEOUT cycles.
module serv_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear, count_en};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT + 1);
      localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

      logic [W-1:0] count_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (count_en) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      // The count equals the number of completed wait cycles, so this fires on the TIMEOUT-th.
      assign expire = count_en && (count_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/serv_mem_arbiter.sv
// Round-robin arbiter sharing one registered Wishbone-style memory port between
// serv's instruction and data buses, with a watchdog that completes hung cycles.
module serv_mem_arbiter
  import serv_arb_pkg::*;
#(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] ERR_RDT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  output logic [3:0]  o_mem_sel,
  output logic        o_mem_we,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack,
  output logic        o_err
);

  state_t      state_reg, state_next;
  logic        owner_reg;
  logic        last_d;
  logic [31:0] rdt_reg;

  logic grant, grant_owner, done, timed_out, busy, expire;

  assign busy = (state_reg == IBUS) || (state_reg == DBUS);

  serv_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .clear   (grant),
    .count_en(busy && !i_mem_ack),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant       = 1'b0;
    grant_owner = OWNER_IBUS;
    done        = 1'b0;
    timed_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie last_d points at the side served most recently, so the other side wins.
        if (i_ibus_cyc && (!i_dbus_cyc || last_d)) begin
          grant      = 1'b1;
          state_next = IBUS;
        end else if (i_dbus_cyc) begin
          grant       = 1'b1;
          grant_owner = OWNER_DBUS;
          state_next  = DBUS;
        end
      end
      IBUS, DBUS: begin
        if (i_mem_ack) begin
          done       = 1'b1;
          state_next = RESP;
        end else if (expire) begin
          done       = 1'b1;
          timed_out  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_reg  <= OWNER_IBUS;
      last_d     <= 1'b1;
      rdt_reg    <= '0;
      o_mem_adr  <= '0;
      o_mem_dat  <= '0;
      o_mem_sel  <= '0;
      o_mem_we   <= 1'b0;
      o_mem_cyc  <= 1'b0;
      o_ibus_ack <= 1'b0;
      o_dbus_ack <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      if (grant) begin
        owner_reg <= grant_owner;
        o_mem_cyc <= 1'b1;
        if (grant_owner == OWNER_DBUS) begin
          o_mem_adr <= i_dbus_adr;
          o_mem_dat <= i_dbus_dat;
          o_mem_sel <= i_dbus_sel;
          o_mem_we  <= i_dbus_we;
        end else begin
          o_mem_adr <= i_ibus_adr;
          o_mem_dat <= '0;
          o_mem_sel <= SEL_FULL;
          o_mem_we  <= WE_READ;
        end
      end
      if (done) begin
        rdt_reg    <= timed_out ? ERR_RDT : i_mem_rdt;
        o_mem_cyc  <= 1'b0;
        o_err      <= timed_out;
        o_ibus_ack <= (owner_reg == OWNER_IBUS);
        o_dbus_ack <= (owner_reg == OWNER_DBUS);
      end
      if (state_reg == RESP) begin
        o_ibus_ack <= 1'b0;
        o_dbus_ack <= 1'b0;
        o_err      <= 1'b0;
        last_d     <= (owner_reg == OWNER_DBUS);
      end
    end
  end

  assign o_ibus_rdt = rdt_reg;
  assign o_dbus_rdt = rdt_reg;

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Randomized transaction-level bench for serv_mem_arbiter against a round-robin reference model.
module tb_serv_mem_arbiter;

  localparam int          TO  = 6;
  localparam logic [31:0] ERR = 32'hBAD0_0BAD;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] o_mem_adr;
  logic [31:0] o_mem_dat;
  logic [3:0]  o_mem_sel;
  logic        o_mem_we;
  logic        o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;
  logic        o_err;

  always #5 clk = ~clk;

  serv_mem_arbiter #(
    .TIMEOUT(TO),
    .ERR_RDT(ERR)
  ) dut (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_ibus_adr(i_ibus_adr),
    .i_ibus_cyc(i_ibus_cyc),
    .o_ibus_rdt(o_ibus_rdt),
    .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr),
    .i_dbus_dat(i_dbus_dat),
    .i_dbus_sel(i_dbus_sel),
    .i_dbus_we (i_dbus_we),
    .i_dbus_cyc(i_dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt),
    .o_dbus_ack(o_dbus_ack),
    .o_mem_adr (o_mem_adr),
    .o_mem_dat (o_mem_dat),
    .o_mem_sel (o_mem_sel),
    .o_mem_we  (o_mem_we),
    .o_mem_cyc (o_mem_cyc),
    .i_mem_rdt (i_mem_rdt),
    .i_mem_ack (i_mem_ack),
    .o_err     (o_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;
  bit last_m;  // model: 1 when dbus was served most recently

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic request(input bit ri, input bit rd);
    if (ri && !i_ibus_cyc) begin
      i_ibus_cyc = 1'b1;
      i_ibus_adr = $urandom;
    end
    if (rd && !i_dbus_cyc) begin
      i_dbus_cyc = 1'b1;
      i_dbus_adr = $urandom;
      i_dbus_dat = $urandom;
      i_dbus_sel = 4'($urandom);
      i_dbus_we  = 1'($urandom);
    end
  endtask

  // d = cycle (1-based, after grant) on which memory acks; 0 or > TO means it never does.
  task automatic do_txn(input int d, input logic [31:0] rdt, input bit late_ack);
    bit          own_d, exp_err;
    int          resp_at;
    logic [31:0] e_adr, e_dat, e_rdt;
    logic [3:0]  e_sel;
    logic        e_we;
    if (i_ibus_cyc && i_dbus_cyc) own_d = !last_m;
    else                          own_d = i_dbus_cyc;
    e_adr   = own_d ? i_dbus_adr : i_ibus_adr;
    e_dat   = own_d ? i_dbus_dat : 32'h0;
    e_sel   = own_d ? i_dbus_sel : 4'hF;
    e_we    = own_d ? i_dbus_we  : 1'b0;
    exp_err = (d < 1) || (d > TO);
    resp_at = exp_err ? TO : d;
    e_rdt   = exp_err ? ERR : rdt;

    @(posedge clk); @(negedge clk);
    check("grant_adr_dat", {o_mem_adr, o_mem_dat}, {e_adr, e_dat});
    check("grant_ctl", {o_mem_sel, o_mem_we, o_mem_cyc, o_ibus_ack, o_dbus_ack, o_err},
          {e_sel, e_we, 4'b1000});

    for (int w = 1; w <= resp_at; w++) begin
      if (own_d) begin
        i_dbus_adr = $urandom;
        i_dbus_dat = $urandom;
        i_dbus_sel = 4'($urandom);
        i_dbus_we  = 1'($urandom);
      end else begin
        i_ibus_adr = $urandom;
      end
      i_mem_ack = (w == d);
      i_mem_rdt = (w == d) ? rdt : 32'($urandom);
      @(posedge clk); @(negedge clk);
      i_mem_ack = 1'b0;
      if (w < resp_at) begin
        check("hold_adr_dat", {o_mem_adr, o_mem_dat}, {e_adr, e_dat});
        check("hold_ctl", {o_mem_sel, o_mem_we, o_mem_cyc, o_ibus_ack, o_dbus_ack, o_err},
              {e_sel, e_we, 4'b1000});
      end
    end

    check("resp_ctl", {o_mem_cyc, o_ibus_ack, o_dbus_ack, o_err}, {1'b0, !own_d, own_d, exp_err});
    check("resp_rdt", own_d ? o_dbus_rdt : o_ibus_rdt, e_rdt);
    n_txn++;
    $display("txn %0d: %s adr=%08h wait=%0d rdt=%08h err=%0b", n_txn, own_d ? "dbus" : "ibus",
             e_adr, resp_at, own_d ? o_dbus_rdt : o_ibus_rdt, o_err);

    if (own_d) i_dbus_cyc = 1'b0;
    else       i_ibus_cyc = 1'b0;
    last_m    = own_d;
    i_mem_ack = late_ack;
    i_mem_rdt = $urandom;
    @(posedge clk); @(negedge clk);
    check("after_resp", {o_mem_cyc, o_ibus_ack, o_dbus_ack, o_err}, 4'b0000);
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_ibus_adr = '0;
    i_ibus_cyc = 1'b0;
    i_dbus_adr = '0;
    i_dbus_dat = '0;
    i_dbus_sel = '0;
    i_dbus_we  = 1'b0;
    i_dbus_cyc = 1'b0;
    i_mem_rdt  = '0;
    i_mem_ack  = 1'b0;
    last_m     = 1'b1;

    #2;
    check("reset_mem", {o_mem_adr, o_mem_dat}, 64'h0);
    check("reset_ctl", {o_mem_sel, o_mem_we, o_mem_cyc, o_ibus_ack, o_dbus_ack, o_err}, 9'h0);
    check("reset_rdt", {o_ibus_rdt, o_dbus_rdt}, 64'h0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;

    // Single fetch, memory acks one cycle after the request appears.
    i_ibus_cyc = 1'b1;
    i_ibus_adr = 32'h0000_0100;
    do_txn(1, 32'h0000_0013, 1'b0);

    // Write held through several wait cycles.
    i_dbus_cyc = 1'b1;
    i_dbus_adr = 32'h0000_2004;
    i_dbus_dat = 32'hDEAD_BEEF;
    i_dbus_sel = 4'b0011;
    i_dbus_we  = 1'b1;
    do_txn(5, 32'h1234_5678, 1'b0);

    // Both buses keep requesting: grants must alternate.
    for (int k = 0; k < 4; k++) begin
      request(1'b1, 1'b1);
      do_txn(2, $urandom, 1'b0);
    end
    while (i_ibus_cyc || i_dbus_cyc) do_txn(1, $urandom, 1'b0);

    // Hung data access with a stray late ack in the response cycle.
    request(1'b0, 1'b1);
    do_txn(0, $urandom, 1'b1);

    // Ack lands on the very cycle the watchdog would expire.
    request(1'b1, 1'b0);
    do_txn(TO, 32'hCAFE_0001, 1'b0);

    // Asynchronous reset in the middle of a data access.
    i_mem_ack = 1'b0;
    request(1'b0, 1'b1);
    @(posedge clk); @(negedge clk); @(posedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_ctl", {o_mem_cyc, o_ibus_ack, o_dbus_ack, o_err}, 4'b0000);
    check("midrst_mem", {o_mem_adr, o_mem_dat}, 64'h0);
    i_dbus_cyc = 1'b0;
    last_m     = 1'b1;
    @(negedge clk);
    i_rst_n = 1'b1;
    request(1'b1, 1'b1);
    do_txn(1, $urandom, 1'b0);
    while (i_ibus_cyc || i_dbus_cyc) do_txn(1, $urandom, 1'b0);

    for (int k = 0; k < 150; k++) begin
      logic [1:0] rb;
      if (!i_ibus_cyc && !i_dbus_cyc && ($urandom_range(0, 3) == 0)) begin
        i_mem_ack = 1'($urandom);
        @(posedge clk); @(negedge clk);
        check("idle", {o_mem_cyc, o_ibus_ack, o_dbus_ack, o_err}, 4'b0000);
      end
      rb = 2'($urandom_range(1, 3));
      request(rb[0], rb[1]);
      do_txn(int'($urandom_range(0, TO + 1)), $urandom, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serv_mem_arbiter.md
# serv_mem_arbiter

Shares a single Wishbone-style memory port between the core's instruction bus and data bus. It sits between `serv_top` and the memory/peripheral interconnect in a single-port memory system. Requests are arbitrated round-robin, and each granted request is registered and held stable until the memory acknowledges. A one-cycle acknowledge pulse is returned to the owner. A watchdog completes hung transactions with an error pulse and fixed read data.

## Interface
- `TIMEOUT`, default 255: cycles a granted transaction may wait for `i_mem_ack` before forced completion; 0 disables the watchdog.
- `ERR_RDT`, default 32'h0000_0000: read data returned on a timed-out transaction.
- `clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_ibus_adr`  in  32  instruction fetch address.
- `i_ibus_cyc`  in  1  fetch request.
- `o_ibus_rdt`  out  32  fetch data, valid while `o_ibus_ack`.
- `o_ibus_ack`  out  1  one-cycle fetch completion.
- `i_dbus_adr`  in  32  data address.
- `i_dbus_dat`  in  32  write data.
- `i_dbus_sel`  in  4  byte lanes.
- `i_dbus_we`  in  1  write enable.
- `i_dbus_cyc`  in  1  data request.
- `o_dbus_rdt`  out  32  load data, valid while `o_dbus_ack`.
- `o_dbus_ack`  out  1  one-cycle data completion.
- `o_mem_adr`  out  32  memory address.
- `o_mem_dat`  out  32  memory write data.
- `o_mem_sel`  out  4  memory byte lanes.
- `o_mem_we`  out  1  memory write enable.
- `o_mem_cyc`  out  1  memory request.
- `i_mem_rdt`  in  32  memory read data.
- `i_mem_ack`  in  1  memory completion.
- `o_err`  out  1  one-cycle pulse when a transaction times out.

## Operation
- FSM states:
  - IDLE: no outstanding transaction.
  - IBUS: fetch granted, waiting for memory.
  - DBUS: data access granted, waiting for memory.
  - RESP: ack pulse to the owner.
- IDLE, grant rules:
  - Only `i_ibus_cyc` high -> IBUS.
  - Only `i_dbus_cyc` high -> DBUS.
  - Both high -> grant the requester not served last, tracked by register `last_d` (1 = dbus was last served).
  - Reset value of `last_d` is 1, so ibus wins the first tie.
- On grant:
  - Capture adr into `o_mem_adr`.
  - For DBUS: also capture dat/sel/we.
  - For IBUS: drive sel=4'hF, we=0, dat=0.
  - Set `o_mem_cyc`=1.
- Captured values stay stable until leaving IBUS/DBUS; requester inputs are ignored after capture.
- IBUS/DBUS:
  - On `i_mem_ack`: capture `i_mem_rdt`, clear `o_mem_cyc`, go to RESP.
  - On watchdog expiry: load `ERR_RDT`, clear `o_mem_cyc`, set the `o_err` flag, go to RESP.
- RESP:
  - Drive the owner's ack=1 for exactly one cycle, with its rdt from the capture register.
  - Update `last_d`, then go to IDLE.
- Non-owner ack stays 0 at all times. Both rdt outputs drive the capture register, which is valid only with ack.
- Watchdog:
  - 8-bit counter, width sized by `$clog2(TIMEOUT+1)`.
  - Clears on grant; increments each cycle in IBUS/DBUS without ack.
  - Expires when count == `TIMEOUT`-1, i.e. `TIMEOUT` wait cycles.
- Boundary rules:
  - Ack and expiry in the same cycle: ack wins, no `o_err`.
  - `i_mem_ack` outside IBUS/DBUS is ignored.
  - A requester dropping cyc mid-transaction is not supported. The arbiter still completes the memory cycle and pulses that requester's ack.
  - A requester whose cyc is still high in the RESP cycle is not re-granted from RESP. Re-grant happens only in IDLE, after the core has dropped cyc.
- Reset (asynchronous, any state, including mid-transaction):
  - FSM to IDLE, `last_d`=1.
  - All outputs 0: `o_mem_*`, both acks, both rdt, `o_err`.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Request seen in IDLE at edge t: `o_mem_cyc`=1 from t+1.
- `i_mem_ack` sampled at edge t+k:
  - `o_mem_cyc`=0 from t+k+1.
  - Owner ack=1 during cycle t+k+1 only.
  - IDLE from t+k+2.
- Minimum request-to-ack latency is 2 cycles; back-to-back grants are 3 cycles apart.
- Timeout: with `TIMEOUT`=N, `o_err` and the owner ack are asserted together in cycle t+N+1.

## Structure
- Package `serv_arb_pkg`:
  - State enum: IDLE/IBUS/DBUS/RESP.
  - Owner encoding constants.
  - IBUS default constants `SEL_FULL`=4'hF and `WE_READ`=0.
- Sub-module `serv_arb_watchdog`:
  - Ports: clear, count-enable, expire output, parameterised by `TIMEOUT`.
  - Ties expire to 0 when `TIMEOUT`=0.

## Test plan
- Single fetch: ibus cyc, adr 0x100, memory acks 1 cycle after `o_mem_cyc` with rdt 0x00000013 -> `o_ibus_ack` 1-cycle pulse with rdt 0x13, `o_mem_sel`=F, `o_mem_we`=0, `o_dbus_ack` stays 0.
- Write: dbus adr 0x2004, dat 0xDEADBEEF, sel 4'b0011, we=1 -> `o_mem_*` match and are held stable across 5 wait cycles; `o_dbus_ack` pulses once.
- Tie: ibus and dbus asserted together twice in succession -> first grant ibus, second grant dbus; alternation continues while both stay asserted.
- Timeout: `TIMEOUT`=4, memory never acks on dbus -> `o_err` and `o_dbus_ack` asserted in cycle 5 after grant with rdt=`ERR_RDT`; a late `i_mem_ack` is ignored.
- Ack and expiry in the same cycle -> normal completion, rdt from memory, `o_err`=0.
- Reset: `i_rst_n` low while in DBUS -> `o_mem_cyc` and all acks 0 immediately; after release, a new ibus request is granted first.
